// File: rtl/if_id_decode_reg_if.sv
// IF/ID stage bus: fetch-side inputs and registered ID-side outputs.
interface if_id_decode_reg_if;
  logic        stall;
  logic        flush;
  logic        valid_in;
  logic [31:0] pc_in;
  logic [31:0] inst_in;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic [2:0]  imm_sel;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        illegal;

  modport master (
    output stall, flush, valid_in, pc_in, inst_in,
    input  valid_out, pc_out, inst_out, imm_sel, rd, rs1, rs2, illegal
  );

  modport slave (
    input  stall, flush, valid_in, pc_in, inst_in,
    output valid_out, pc_out, inst_out, imm_sel, rd, rs1, rs2, illegal
  );
endinterface

// File: rtl/if_id_decode_reg.sv
// IF/ID pipeline register for RV32I with immediate-format pre-decode.
// Flush beats stall; reset beats both.
module if_id_decode_reg #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  if_id_decode_reg_if.slave  bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned SELW  = 3;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [SELW-1:0] IMM_NONE  = 3'b000;
  localparam logic [SELW-1:0] IMM_J     = 3'b001;
  localparam logic [SELW-1:0] IMM_B     = 3'b010;
  localparam logic [SELW-1:0] IMM_I     = 3'b011;
  localparam logic [SELW-1:0] IMM_S     = 3'b100;
  localparam logic [SELW-1:0] IMM_U     = 3'b101;
  localparam logic [SELW-1:0] IMM_SHAMT = 3'b111;

  logic            valid_q,   valid_d;
  logic [XLEN-1:0] pc_q,      pc_d;
  logic [XLEN-1:0] inst_q,    inst_d;
  logic [SELW-1:0] imm_sel_q, imm_sel_d;
  logic            illegal_q, illegal_d;

  logic [SELW-1:0] dec_imm_sel;
  logic            dec_illegal;
  logic [6:0]      opc;
  logic [2:0]      f3;

  assign opc = bus.inst_in[6:0];
  assign f3  = bus.inst_in[14:12];

  // Format decode of the incoming word; low bits != 2'b11 fall to default.
  always_comb begin
    dec_imm_sel = IMM_NONE;
    dec_illegal = 1'b0;
    case (opc)
      OPC_OP_IMM:                     dec_imm_sel = (f3 == 3'b001 || f3 == 3'b101) ? IMM_SHAMT : IMM_I;
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: dec_imm_sel = IMM_I;
      OPC_STORE:                      dec_imm_sel = IMM_S;
      OPC_BRANCH:                     dec_imm_sel = IMM_B;
      OPC_JAL:                        dec_imm_sel = IMM_J;
      OPC_LUI, OPC_AUIPC:             dec_imm_sel = IMM_U;
      OPC_OP, OPC_FENCE:              dec_imm_sel = IMM_NONE;
      default:                        dec_illegal = 1'b1;
    endcase
  end

  // Next-state selection: flush, then hold on stall, then capture.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    imm_sel_d = imm_sel_q;
    illegal_d = illegal_q;
    if (bus.flush) begin
      valid_d   = 1'b0;
      pc_d      = RESET_PC;
      inst_d    = NOP_INST;
      imm_sel_d = IMM_I;
      illegal_d = 1'b0;
    end else if (!bus.stall) begin
      pc_d = bus.pc_in;
      if (bus.valid_in) begin
        valid_d   = 1'b1;
        inst_d    = bus.inst_in;
        imm_sel_d = dec_imm_sel;
        illegal_d = dec_illegal;
      end else begin
        valid_d   = 1'b0;
        inst_d    = NOP_INST;
        imm_sel_d = IMM_I;
        illegal_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= RESET_PC;
      inst_q    <= NOP_INST;
      imm_sel_q <= IMM_I;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      imm_sel_q <= imm_sel_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.pc_out    = pc_q;
  assign bus.inst_out  = inst_q;
  assign bus.imm_sel   = imm_sel_q;
  assign bus.illegal   = illegal_q;
  assign bus.rd        = inst_q[11:7];
  assign bus.rs1       = inst_q[19:15];
  assign bus.rs2       = inst_q[24:20];
endmodule

// File: tb/tb_if_id_decode_reg.sv
// Directed plus randomized bench for if_id_decode_reg against a table-driven model.
module tb_if_id_decode_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  if_id_decode_reg_if bus ();

  if_id_decode_reg #(
    .NOP_INST(32'h0000_0013),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state of the ID stage
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [2:0]  m_imm;
  logic        m_ill;

  // Opcode -> format table, returns {illegal, imm_sel}
  function automatic logic [3:0] ref_decode(input logic [31:0] w);
    logic [2:0] f3;
    f3 = w[14:12];
    case (w[6:0])
      7'h13:                return (f3 == 3'd1 || f3 == 3'd5) ? 4'b0111 : 4'b0011;
      7'h03, 7'h67, 7'h73:  return 4'b0011;
      7'h23:                return 4'b0100;
      7'h63:                return 4'b0010;
      7'h6F:                return 4'b0001;
      7'h37, 7'h17:         return 4'b0101;
      7'h33, 7'h0F:         return 4'b0000;
      default:              return 4'b1000;
    endcase
  endfunction

  task automatic model_bubble(input logic [31:0] pc);
    m_valid = 1'b0; m_pc = pc; m_inst = 32'h0000_0013; m_imm = 3'b011; m_ill = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    logic [3:0] d;
    check("valid_out", 32'(bus.valid_out), 32'(m_valid));
    check("pc_out",    bus.pc_out,         m_pc);
    check("inst_out",  bus.inst_out,       m_inst);
    check("imm_sel",   32'(bus.imm_sel),   32'(m_imm));
    check("illegal",   32'(bus.illegal),   32'(m_ill));
    check("rd",        32'(bus.rd),        32'(m_inst[11:7]));
    check("rs1",       32'(bus.rs1),       32'(m_inst[19:15]));
    check("rs2",       32'(bus.rs2),       32'(m_inst[24:20]));
    d = ref_decode(32'h0);
  endtask

  // Drive one cycle, advance the model, sample 1 time unit after the edge
  task automatic step(input logic r, input logic s, input logic f, input logic v,
                      input logic [31:0] pc, input logic [31:0] inst);
    logic [3:0] d;
    rst = r; bus.stall = s; bus.flush = f; bus.valid_in = v; bus.pc_in = pc; bus.inst_in = inst;
    @(posedge clk);
    if (r)       model_bubble(32'h0);
    else if (f)  model_bubble(32'h0);
    else if (!s) begin
      if (v) begin
        d = ref_decode(inst);
        m_valid = 1'b1; m_pc = pc; m_inst = inst; m_imm = d[2:0]; m_ill = d[3];
      end else model_bubble(pc);
    end
    #1;
    check_all();
  endtask

  logic [31:0] sweep_inst [7] = '{32'h00A00093, 32'h00311093, 32'h00112423, 32'h00208463,
                                  32'h008000EF, 32'h123450B7, 32'h002081B3};
  logic [2:0]  sweep_imm  [7] = '{3'b011, 3'b111, 3'b100, 3'b010, 3'b001, 3'b101, 3'b000};
  logic [6:0]  legal_opc  [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                                   7'h6F, 7'h37, 7'h17, 7'h33, 7'h0F};

  initial begin
    logic [31:0] w;
    model_bubble(32'h0);
    bus.stall = 1'b0; bus.flush = 1'b0; bus.valid_in = 1'b0;
    bus.pc_in = 32'h0; bus.inst_in = 32'h0;

    // Reset held with stall asserted
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h00A00093);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h00A00093);
    check("rst_inst", bus.inst_out, 32'h0000_0013);
    check("rst_imm",  32'(bus.imm_sel), 32'd3);

    // Format sweep
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h1000 + 32'(4 * i), sweep_inst[i]);
      check("sweep_imm", 32'(bus.imm_sel), 32'(sweep_imm[i]));
    end

    // Field slicing on the add still in the stage
    check("slice_rd",  32'(bus.rd),  32'd3);
    check("slice_rs1", 32'(bus.rs1), 32'd1);
    check("slice_rs2", 32'(bus.rs2), 32'd2);

    // Stall holds for three cycles, then releases
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h100, 32'h00A00093);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h104, 32'h00112423);
      check("stall_pc", bus.pc_out, 32'h100);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h104, 32'h00112423);
    check("release_pc",  bus.pc_out, 32'h104);
    check("release_imm", 32'(bus.imm_sel), 32'd4);

    // Flush wins over stall
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h108, 32'h00208463);
    check("flush_valid", 32'(bus.valid_out), 32'd0);
    check("flush_pc",    bus.pc_out, 32'h0);

    // Illegal opcode, then a bubble keeping the debug PC
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h1FC, 32'h0000007F);
    check("illegal_flag", 32'(bus.illegal), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h00112423);
    check("bubble_pc",   bus.pc_out, 32'h200);
    check("bubble_inst", bus.inst_out, 32'h0000_0013);

    // Reset arriving mid-stall
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 32'h123450B7);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h304, 32'h00A00093);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h304, 32'h00A00093);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(0, 9) < 8) w[6:0] = legal_opc[$urandom_range(0, 10)];
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) != 0), $urandom, w);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/if_id_decode_reg.md
# if_id_decode_reg

IF/ID pipeline register with instruction-format pre-decode for the RV32I core. Captures the fetched instruction and its PC each cycle and produces the registered `inst` and `imm_sel` codes consumed by the immediate generator in the ID stage. It also exposes the register-address fields and an illegal-opcode flag. Stall holds the stage and flush inserts a bubble.

## Interface
- `NOP_INST`, default 32'h0000_0013: bubble instruction (`addi x0,x0,0`) loaded on reset and flush.
- `RESET_PC`, default 32'h0000_0000: `pc_out` value after reset and flush.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `stall`  in  1  hold all registers this cycle.
- `flush`  in  1  load a bubble this cycle; wins over `stall`.
- `valid_in`  in  1  fetch output is a real instruction.
- `pc_in`  in  32  PC of the fetched instruction.
- `inst_in`  in  32  fetched instruction word.
- `valid_out`  out  1  ID-stage instruction is real.
- `pc_out`  out  32  registered PC.
- `inst_out`  out  32  registered instruction; drives the immediate generator's `inst`.
- `imm_sel`  out  3  registered format code; drives the immediate generator's `imm_sel`.
- `rd`, `rs1`, `rs2`  out  5 each  `inst_out[11:7]`, `[19:15]`, `[24:20]`; combinational from `inst_out`.
- `illegal`  out  1  registered; opcode is not recognised and `valid_out`=1.

## Operation
- Each register update selects exactly one of four actions, checked in this priority order:
  - `rst`=1: load the reset values.
  - `flush`=1: load the bubble.
  - `stall`=1: hold the current contents.
  - Otherwise: capture the inputs.
- Reset values and bubble contents are identical:
  - `inst_out`=`NOP_INST`, `pc_out`=`RESET_PC`, `valid_out`=0.
  - `imm_sel`=3'b011, `illegal`=0.
- Capture with `valid_in`=0 loads the bubble. `pc_out` still captures `pc_in`, for debug.
- Capture with `valid_in`=1:
  - `inst_out`←`inst_in`, `pc_out`←`pc_in`, `valid_out`←1.
  - `imm_sel` and `illegal` are decoded from `inst_in` in the same cycle.
- `imm_sel` decode uses `opc`=`inst_in[6:0]` and `f3`=`inst_in[14:12]`:
  - 0010011 (OP-IMM): `f3`=001 or 101 gives 3'b111 (shamt); all other `f3` give 3'b011 (I).
  - 0000011 (LOAD), 1100111 (JALR), 1110011 (SYSTEM): 3'b011 (I).
  - 0100011 (STORE): 3'b100 (S).
  - 1100011 (BRANCH): 3'b010 (B).
  - 1101111 (JAL): 3'b001 (J).
  - 0110111 (LUI), 0010111 (AUIPC): 3'b101 (U).
  - 0110011 (OP), 0001111 (FENCE): 3'b000 (no immediate).
  - Any other opcode: 3'b000 with `illegal`=1.
- Codes 3'b110 and unlisted encodings are never produced.
- No funct7 checking: SRAI vs SRLI is decided downstream.
- `inst_in[1:0]`≠2'b11 counts as an unrecognised opcode and sets `illegal`=1.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on the outputs after edge N.
- All outputs are registered except `rd`, `rs1` and `rs2`, which are pure slices of `inst_out`.
- Reset takes effect at the first rising edge with `rst`=1, whatever the `stall`/`flush` values.
- Outputs hold their reset values until the first capture edge after `rst` falls.
- `stall`=1 holds for an unlimited number of cycles; outputs stay bit-identical.
- `stall` and `flush` both 1: the bubble is loaded and the stall is ignored for this stage.
- `flush` lasts one cycle; a bubble arrives one cycle after the flush edge.
- Reset asserted mid-stall: the reset values are loaded and the stall is irrelevant.
- No combinational path from any input to any output.

## Test plan
- Reset: `rst`=1 for 2 cycles with `stall`=1, `flush`=0 → `inst_out`=0x00000013, `pc_out`=0, `valid_out`=0, `imm_sel`=011, `illegal`=0.
- Format sweep: feed one instruction per cycle, `valid_in`=1, no stall. Each output appears one cycle later:
  - 0x00A00093 (addi) → 011.
  - 0x00311093 (slli) → 111.
  - 0x00112423 (sw) → 100.
  - 0x00208463 (beq) → 010.
  - 0x008000EF (jal) → 001.
  - 0x123450B7 (lui) → 101.
  - 0x002081B3 (add) → 000.
- Stall: capture pc 0x100 / 0x00A00093, then `stall`=1 for 3 cycles while the inputs change to pc 0x104 / 0x00112423 → outputs stay at pc 0x100 / 0x00A00093; after release, the next edge shows 0x104 / 0x00112423, `imm_sel`=100.
- Flush over stall: `stall`=1 and `flush`=1 with a valid instruction held in the stage → next cycle `valid_out`=0, `inst_out`=0x00000013, `pc_out`=`RESET_PC`.
- Illegal and bubble:
  - `inst_in`=0x0000007F, `valid_in`=1 → `illegal`=1, `imm_sel`=000, `valid_out`=1.
  - Next cycle, `valid_in`=0 with pc 0x200 → `valid_out`=0, `illegal`=0, `inst_out`=NOP, `pc_out`=0x200.
- Field slicing: `inst_out`=0x002081B3 → `rd`=3, `rs1`=1, `rs2`=2.
